// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// 7-segment bank. It drives one shared registered bin-to-7-seg decoder and
// the active-low digit anodes. The anode enables lag bin_out by one cycle so
// that they line up with the decoder's output register.
// Optional feature macro: SEG_SCAN_GHOST_BLANK_EN inserts an all-off BLANK
// gap between digits. When it is undefined, SHOW steps directly from one
// digit to the next.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 27000,
  parameter int BLANK_CYCLES = 270
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [3:0]              bin_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    scan_tick
);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || DWELL_CYCLES < 2 || BLANK_CYCLES < 1) begin : g_param_err
    $error("seg_scan_ctrl: parameter out of range");
  end

  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
`ifdef SEG_SCAN_GHOST_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    tick_nxt;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] pending_dig, shadow_dig, shadow_dig_nxt;
  logic [NUM_DIGITS-1:0]   pending_dp, shadow_dp, shadow_dp_nxt;
  logic [3:0]              bin_nxt;

  // State, digit index and dwell counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef SEG_SCAN_GHOST_BLANK_EN
      state <= BLANK;
`else
      state <= SHOW;
`endif
      idx <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. The counter restarts at zero on every state or index change.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 1'b1;
    tick_nxt  = 1'b0;
    wrap      = 1'b0;
`ifdef SEG_SCAN_GHOST_BLANK_EN
    if (state == BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_nxt = SHOW;
        cnt_nxt   = '0;
      end
    end else
`endif
    if (cnt == DWELL_LAST) begin
      cnt_nxt  = '0;
      tick_nxt = 1'b1;
      wrap     = (idx == IDX_LAST);
      idx_nxt  = wrap ? '0 : idx + 1'b1;
`ifdef SEG_SCAN_GHOST_BLANK_EN
      state_nxt = BLANK;
`endif
    end
  end

  // Shadow update at a frame wrap. A load on the wrap cycle bypasses the pending register.
  always_comb begin
    shadow_dig_nxt = shadow_dig;
    shadow_dp_nxt  = shadow_dp;
    if (wrap) begin
      if (load) begin
        shadow_dig_nxt = digits_in;
        shadow_dp_nxt  = dp_in;
      end else begin
        shadow_dig_nxt = pending_dig;
        shadow_dp_nxt  = pending_dp;
      end
    end
    bin_nxt = shadow_dig_nxt[{idx_nxt, 2'b00} +: 4];
  end

  // Pending buffer captures each load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_dig <= '0;
      pending_dp  <= '0;
    end else if (load) begin
      pending_dig <= digits_in;
      pending_dp  <= dp_in;
    end
  end

  // Shadow buffer is the display source and changes only at frame boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_dig <= '0;
      shadow_dp  <= '0;
    end else begin
      shadow_dig <= shadow_dig_nxt;
      shadow_dp  <= shadow_dp_nxt;
    end
  end

  // Output registers. bin_out follows idx immediately; the enables and dp lag it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out   <= '0;
      scan_tick <= 1'b0;
      dig_en_n  <= '1;
      dp_out    <= 1'b1;
    end else begin
      bin_out   <= bin_nxt;
      scan_tick <= tick_nxt;
      if (state == SHOW) begin
        dig_en_n <= ~(NUM_DIGITS'(1) << idx);
        dp_out   <= ~shadow_dp[idx];
      end else begin
        dig_en_n <= '1;
        dp_out   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the clock's common-anode 7-segment display bank. It owns a single shared `bin_to_7_seg` decoder and sequences it across `NUM_DIGITS` digits, presenting one 4-bit value at a time and driving the matching active-low digit enable. Enable timing is aligned to the decoder's one-cycle registered latency. Digit values are double-buffered, so a new time value appears only at a frame boundary.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of multiplexed digits, legal range 2..8.
- `DWELL_CYCLES`, default 27000: cycles each digit is lit; 1 ms at 27 MHz; minimum 2.
- `BLANK_CYCLES`, default 270: all-off gap between digits; minimum 1. Used only with `SEG_SCAN_GHOST_BLANK_EN`.

Ports:
- `clk` in 1: system clock. The block has one clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `digits_in` in 4*`NUM_DIGITS`: digit values; digit i is `digits_in[4i+3:4i]`; digit 0 is the rightmost digit.
- `dp_in` in `NUM_DIGITS`: decimal-point request per digit.
- `load` in 1: one-cycle strobe that captures `digits_in` and `dp_in`.
- `bin_out` out 4: value to the shared decoder's `bin` input.
- `dp_out` out 1: decimal point, aligned with `dig_en_n`; active-low.
- `dig_en_n` out `NUM_DIGITS`: digit anode enables; active-low; at most one bit low at any time.
- `scan_tick` out 1: one-cycle pulse on each digit advance.

## Operation
- **Buffers.** The block holds a pending register and a shadow register, each `4*NUM_DIGITS+NUM_DIGITS` bits wide.
  - `load` writes the pending register.
  - The shadow register is copied from pending on the frame-wrap cycle, when the index goes from `NUM_DIGITS-1` to 0.
  - If `load` is high on the wrap cycle, shadow takes `digits_in`/`dp_in` directly, bypassing pending.
  - The display always reads from shadow.
- **State machine (with macro).**
  - BLANK: all enables off for `BLANK_CYCLES` cycles, then go to SHOW.
  - SHOW: digit `idx` is lit for `DWELL_CYCLES` cycles.
  - On SHOW expiry: `idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1`, pulse `scan_tick`, go to BLANK.
- **Decoder drive.** `bin_out` is updated to `shadow[idx]` in the same cycle `idx` changes. It is therefore stable throughout BLANK.
- **Enable alignment.**
  - `dig_en_n` and `dp_out` are registered one cycle after the state/`idx` update, matching the decoder's output register.
  - In SHOW, `dig_en_n = ~(1<<idx)`; otherwise all ones.
  - `dp_out = ~shadow_dp[idx]` in SHOW; otherwise 1.
- **Dwell counter.** Width is `$clog2(max(DWELL_CYCLES,BLANK_CYCLES))`. It reloads to 0 on every state or `idx` change and never wraps mid-state.
- **Reset values (asynchronous, in effect while `rst` is high).**
  - State = BLANK (SHOW without macro), `idx` = 0, counter = 0.
  - Pending and shadow registers = 0.
  - `bin_out` = 0, `dig_en_n` = all ones, `dp_out` = 1, `scan_tick` = 0.
- **Reset mid-operation.** All of the above take effect immediately; scanning restarts from digit 0. Any captured `load` data is lost.
- **Parameter check.** Out-of-range parameters trigger a simulation `$error` at elaboration.

## Timing
- Edge 1 is the first rising edge after `rst` falls.
- With macro:
  - Digit period is `DWELL_CYCLES+BLANK_CYCLES`; frame period is `NUM_DIGITS*(DWELL_CYCLES+BLANK_CYCLES)`.
  - The first `dig_en_n` low occurs after edge `BLANK_CYCLES+1`.
- Without macro:
  - Digit period is `DWELL_CYCLES`.
  - `dig_en_n[0]` goes low after edge 1.
- `scan_tick` is high for exactly one cycle, registered in the same cycle as the `idx` change.
- `load`-to-display latency is at most one frame plus 1 cycle.

## Configuration
- `SEG_SCAN_GHOST_BLANK_EN` defined:
  - The BLANK state is present.
  - Every digit change inserts `BLANK_CYCLES` of all-anodes-off to suppress ghosting.
- Not defined:
  - No BLANK state; `BLANK_CYCLES` is ignored.
  - SHOW advances directly to the next `idx`.
  - `dig_en_n` switches from one digit to the next in a single registered step, still lagging `bin_out` by 1 cycle.

## Test plan
All scenarios use `NUM_DIGITS=4`, `DWELL_CYCLES=8`, `BLANK_CYCLES=2`, macro defined unless stated.

- **Reset.** Pulse `rst`.
  - During reset: `dig_en_n=4'b1111`, `bin_out=0`, `dp_out=1`, `scan_tick=0`.
  - After release: `dig_en_n=4'b1110` after edge 3 and held through edge 10; back to `4'b1111` after edge 11; `4'b1101` after edge 13.
- **Frame scan.**
  - Stimulus: `load` with `digits_in=16'h1234`, `dp_in=4'b0100`.
  - Required: after the next wrap, `bin_out` cycles 4,3,2,1 with `idx` 0..3; `dp_out=0` only while `dig_en_n=4'b1011`; `scan_tick` appears every 10 cycles.
- **Tear-free update.**
  - Stimulus: `load 16'hABCD` while `idx=2`.
  - Required: digits 2 and 3 still show the old values; `bin_out=4'hD` only after the wrap to `idx` 0.
- **Load on wrap cycle.**
  - Stimulus: assert `load` (`16'h5678`) exactly on the wrap cycle.
  - Required: `bin_out=8` in the following cycle; no old value is shown for digit 0.
- **Reset mid-SHOW.**
  - Stimulus: assert `rst` while `idx=2` is lit.
  - Required: `dig_en_n=4'b1111` asynchronously, before the next edge; after release, scanning restarts at digit 0 showing 0.
- **Macro undefined.**
  - Required: `dig_en_n` goes `1110→1101→1011→0111` every 8 cycles with no all-ones gap; `dig_en_n` lags `bin_out` by exactly 1 cycle.
